nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that computes wide additions on the team's existing 4-bit `full_adder` datapath. It accepts a `4*NIBBLES`-bit operand pair and a carry-in through a valid/ready handshake. It then drives the adder one nibble per cycle, least significant nibble first, carrying between cycles in a register. Once the final nibble completes, it presents the assembled sum, carry-out and signed-overflow flag through a second valid/ready handshake. It sits between an operand producer and any consumer that needs wide sums without replicating the adder.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices per operand; operand width `W = 4*NIBBLES`; legal range 2..8.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand pair and `in_c` are valid.
- `in_ready` out 1: block can accept operands.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_c` in 1: carry-in to nibble 0.
- `out_valid` out 1: result fields are valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out W: A + B + c_in, modulo 2^W.
- `out_c` out 1: carry-out of the top nibble.
- `out_ovf` out 1: two's-complement overflow.
- `busy` out 1: high in CALC and DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE:** `in_ready`=1.
  - On `in_valid & in_ready`, load A/B into shift registers and load the carry register from `in_c`.
  - Clear the nibble index and the result register, then go to CALC.
- **CALC:** `in_ready`=0.
  - The adder sees `a`=A[3:0] and `b`=B[3:0] from the shift registers, and `c_in` from the carry register.
  - Each edge: shift the adder `s` into the top of the result register (right-shift), store `c_out` into the carry register, right-shift A/B by 4, and increment the index.
  - On the edge where index == NIBBLES-1, also capture `out_ovf` = (A nibble MSB == B nibble MSB) & (s MSB != A nibble MSB), then go to DONE.
- **DONE:** `out_valid`=1.
  - `out_sum`, `out_c` and `out_ovf` are held stable while `out_valid & !out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_valid` during CALC or DONE is ignored; the producer must hold it (standard valid/ready).
- `in_a`/`in_b`/`in_c` are sampled only on the accept edge. Later input changes do not affect the operation in flight.
- Arithmetic: unsigned modulo 2^W with carry out. `out_ovf` is meaningful only for signed interpretation and is always produced.

## Timing
- **Reset values:**
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `out_sum`=0, `out_c`=0, `out_ovf`=0.
  - Carry register, index and shift registers all 0.
- **Latency:** accept on edge E0; CALC occupies cycles E0..E0+NIBBLES; `out_valid` is high after edge E0+NIBBLES (4 cycles for the default).
- **Throughput:** with `out_ready` tied high, one operation every NIBBLES+2 cycles. There is no accept in the same cycle as the result handshake, because `in_ready`=0 in DONE.
- **Back-pressure:** DONE is held indefinitely while `out_ready`=0, with no change to the outputs.
- **Mid-operation reset:** asserting `rst_n`=0 in any state immediately forces the reset values and drops the result, with no `out_valid` pulse. After deassertion the block is in IDLE with `in_ready`=1.
- **Index wrap:** the index never exceeds NIBBLES-1; it clears on accept.
- **Carry propagation:** a carry generated in nibble k affects nibble k+1 on the next cycle only. There is no combinational path from `in_*` to `out_*`.

## Structure
- Shared package/include: FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the `NIBBLE_W`=4 constant.
- One sub-module instance: the existing `full_adder` (ports `a`[3:0], `b`[3:0], `c_in`, `c_out`, `s`[3:0]), instantiated once and driven purely combinationally from the shift/carry registers.
- Everything else (FSM, index counter, shift registers, result register) lives in this module.

## Test plan
- **Plain sum:** A=0x1234, B=0x4321, c=0 → after 4 cycles `out_sum`=0x5555, `out_c`=0, `out_ovf`=0.
- **Full carry ripple:** A=0xFFFF, B=0x0001, c=0 → `out_sum`=0x0000, `out_c`=1, `out_ovf`=0; the carry crosses all 4 nibbles.
- **Signed overflow:** A=0x7FFF, B=0x0001, c=0 → `out_sum`=0x8000, `out_c`=0, `out_ovf`=1. Also A=0x8000, B=0x8000 → `out_sum`=0x0000, `out_c`=1, `out_ovf`=1.
- **Carry-in:** A=0x0000, B=0x0000, c=1 → `out_sum`=0x0001. A=0xFFFF, B=0x0000, c=1 → `out_sum`=0x0000, `out_c`=1.
- **Back-pressure and input isolation:**
  - Hold `out_ready`=0 for 10 cycles → `out_valid` and `out_sum` stay stable and `in_ready` stays 0.
  - Change `in_a` during CALC → the result is unaffected.
  - Release `out_ready` → IDLE the next cycle.
- **Reset mid-CALC:** drop `rst_n` at the 2nd CALC cycle → all outputs immediately reach their reset values. A new operation after release (A=0x0010, B=0x0020) gives 0x0030.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM encodings and slice width.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_full_adder.sv
// The team's 4-bit full_adder slice: purely combinational nibble add with carry in/out.
module full_adder
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic                c_out,
    output logic [NIBBLE_W-1:0] s
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, c_in};
    assign s     = total[NIBBLE_W-1:0];
    assign c_out = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built from one shared 4-bit full_adder, processing one nibble per cycle
// LSB first, with valid/ready handshakes on both the operand and result sides.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_c,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_c,
    output logic                        out_ovf,
    output logic                        busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t state;
    state_t state_next;

    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [W-1:0]        result;
    logic                carry;
    logic                ovf;
    logic [IDX_W-1:0]    idx;

    logic [NIBBLE_W-1:0] fa_s;
    logic                fa_c;
    logic                accept;
    logic                last_nibble;

    full_adder u_full_adder (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_sh[NIBBLE_W-1:0]),
        .c_in  (carry),
        .c_out (fa_c),
        .s     (fa_s)
    );

    assign accept      = (state == IDLE) && in_valid;
    assign last_nibble = (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_nibble) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sum nibbles enter at the top of the result and drift down, so after the
    // last slice nibble 0 sits in the low bits. The index stops at the last
    // slice rather than wrapping so it never exceeds NIBBLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_sh   <= in_a;
            b_sh   <= in_b;
            result <= '0;
            carry  <= in_c;
            ovf    <= 1'b0;
            idx    <= '0;
        end else if (state == CALC) begin
            result <= {fa_s, result[W-1:NIBBLE_W]};
            carry  <= fa_c;
            a_sh   <= a_sh >> NIBBLE_W;
            b_sh   <= b_sh >> NIBBLE_W;
            if (last_nibble) begin
                ovf <= (a_sh[NIBBLE_W-1] == b_sh[NIBBLE_W-1]) &&
                       (fa_s[NIBBLE_W-1] != a_sh[NIBBLE_W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum = result;
    assign out_c   = carry;
    assign out_ovf = ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a cycle-level behavioural model.
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_c;
    logic         out_ovf;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 0;

    // Model: busy from accept until the result handshake, result due NIBBLES cycles after accept
    bit           m_busy;
    int           m_cnt;
    logic [W-1:0] m_sum;
    logic         m_c;
    logic         m_ovf;

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model_total(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
        logic [W:0] t;
        t = model_total(a, b, c);
        return (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_sum  <= '0;
            m_c    <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                {m_c, m_sum} <= model_total(in_a, in_b, in_c);
                m_ovf        <= model_ovf(in_a, in_b, in_c);
                m_busy       <= 1'b1;
                m_cnt        <= 0;
            end
        end else if (m_cnt < NIBBLES) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("in_ready", 32'(in_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("out_valid", 32'(out_valid), 32'(m_busy && m_cnt == NIBBLES));
            if (m_busy && m_cnt == NIBBLES) begin
                check("model_sum", 32'(out_sum), 32'(m_sum));
                check("model_c", 32'(out_c), 32'(m_c));
                check("model_ovf", 32'(out_ovf), 32'(m_ovf));
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] exp_sum,
                               input logic exp_c, input logic exp_ovf);
        check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, "_c"}, 32'(out_c), 32'(exp_c));
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        check({name, "_model_pin"}, 32'({m_c, m_ovf, m_sum}), 32'({exp_c, exp_ovf, exp_sum}));
    endtask

    // Offers one operand pair, scrambles the inputs after the accept edge and
    // waits (bounded) for the result; hold > 0 keeps out_ready low that long.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input int hold, output bit got);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_a      = a;
        in_b      = b;
        in_c      = c;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = W'($urandom);
        in_c     = ~c;
        got      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("result_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic runVector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic [W-1:0] exp_sum, input logic exp_c,
                             input logic exp_ovf, input int hold);
        bit got;
        applyStimulus(a, b, c, hold, got);
        if (got) begin
            checkOutput(name, exp_sum, exp_c, exp_ovf);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, "_held_valid"}, 32'(out_valid), 32'd1);
                check({name, "_held_sum"}, 32'(out_sum), 32'(exp_sum));
                check({name, "_held_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({name, "_back_to_idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        $display("[TB] starting nibble_serial_adder_ctrl bench");
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outputs", 32'({out_sum, out_c, out_ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 cmp_en = 1'b1;

        runVector("plain",      16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        runVector("ripple",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        runVector("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        runVector("ovf_neg",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        runVector("cin_zero",   16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 0);
        runVector("cin_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        runVector("backpress",  16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0, 10);
        runVector("mixed",      16'hA5C3, 16'h5A3D, 1'b1, 16'h0001, 1'b1, 1'b0, 0);

        // Reset during the second CALC cycle must drop the operation at once
        @(negedge clk);
        in_a     = 16'hFFFF;
        in_b     = 16'h0001;
        in_c     = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outputs", 32'({out_sum, out_c, out_ovf}), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_no_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        runVector("after_rst", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
